// File: rtl/fifo_pkg.sv
// Shared widths and pointer/count types for the ram32x4-backed FIFO controller.
package fifo_pkg;
    localparam int FIFO_ADDR_W = 5;
    localparam int FIFO_DATA_W = 4;
    localparam int FIFO_DEPTH  = 1 << FIFO_ADDR_W;

    typedef logic [FIFO_ADDR_W-1:0] ptr_t;
    typedef logic [FIFO_ADDR_W:0]   cnt_t;

    localparam cnt_t FIFO_FULL_CNT = cnt_t'(FIFO_DEPTH);

    // Pointers wrap silently at DEPTH because the type is exactly ADDR_W bits wide.
    function automatic ptr_t ptr_inc(input ptr_t p);
        return p + ptr_t'(1);
    endfunction
endpackage

// File: rtl/ram32x4.sv
// Behavioural model of the 32x4 dual-port RAM: registered read address, unregistered q.
module ram32x4 import fifo_pkg::*; (
    input  logic                   clock,
    input  logic [FIFO_DATA_W-1:0] data,
    input  ptr_t                   wraddress,
    input  ptr_t                   rdaddress,
    input  logic                   wren,
    output logic [FIFO_DATA_W-1:0] q
);
    logic [FIFO_DATA_W-1:0] mem [FIFO_DEPTH];
    ptr_t                   rdaddr_q;

    always_ff @(posedge clock) begin
        if (wren)
            mem[wraddress] <= data;
        rdaddr_q <= rdaddress;
    end

    assign q = mem[rdaddr_q];
endmodule

// File: rtl/fifo_ctrl.sv
// Synchronous FIFO controller around ram32x4: pointers, occupancy, one-cycle pop latency
// and sticky overflow/underflow flags.
module fifo_ctrl import fifo_pkg::*; #(
    parameter int ADDR_W = FIFO_ADDR_W,
    parameter int DATA_W = FIFO_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              pop,
    input  logic              clear_err,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow
);
    ptr_t              wr_ptr;
    ptr_t              rd_ptr;
    cnt_t              count_q;
    logic              pending;
    logic              push_acc;
    logic              pop_acc;
    logic [DATA_W-1:0] ram_q;

    // Flags come from occupancy, not pointer compare: pointers are equal both when empty and full.
    assign full     = (count_q == FIFO_FULL_CNT);
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign push_acc = push & ~full;
    assign pop_acc  = pop & ~empty;

    ram32x4 u_ram (
        .clock     (clk),
        .data      (wr_data),
        .wraddress (wr_ptr),
        .rdaddress (rd_ptr),
        .wren      (push_acc),
        .q         (ram_q)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count_q   <= '0;
            pending   <= 1'b0;
            rd_valid  <= 1'b0;
            rd_data   <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push_acc)
                wr_ptr <= ptr_inc(wr_ptr);
            if (pop_acc)
                rd_ptr <= ptr_inc(rd_ptr);

            case ({push_acc, pop_acc})
                2'b10:   count_q <= count_q + cnt_t'(1);
                2'b01:   count_q <= count_q - cnt_t'(1);
                default: count_q <= count_q;
            endcase

            // RAM latches rd_ptr on the pop edge, so q is ready to capture one edge later.
            pending  <= pop_acc;
            rd_valid <= pending;
            if (pending)
                rd_data <= ram_q;

            // A new error outranks a simultaneous clear.
            if (push && full)
                overflow <= 1'b1;
            else if (clear_err)
                overflow <= 1'b0;

            if (pop && empty)
                underflow <= 1'b1;
            else if (clear_err)
                underflow <= 1'b0;
        end
    end
endmodule

// File: tb/tb_fifo_ctrl.sv
// Directed bench for fifo_ctrl: ordering, latency, full/empty boundaries, wrap, error flags, reset.
module tb_fifo_ctrl;
    logic       clk = 1'b0;
    logic       reset;
    logic       push;
    logic [3:0] wr_data;
    logic       pop;
    logic       clear_err;
    logic [3:0] rd_data;
    logic       rd_valid;
    logic       full;
    logic       empty;
    logic [5:0] count;
    logic       overflow;
    logic       underflow;

    int n_chk = 0;
    int n_err = 0;

    fifo_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .wr_data   (wr_data),
        .pop       (pop),
        .clear_err (clear_err),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic p, input logic q, input logic [3:0] d, input logic c);
        @(negedge clk);
        push      = p;
        pop       = q;
        wr_data   = d;
        clear_err = c;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_empty"}, 32'(empty), 1);
        chk({tag, "_full"}, 32'(full), 0);
        chk({tag, "_count"}, 32'(count), 0);
        chk({tag, "_ovf"}, 32'(overflow), 0);
        chk({tag, "_udf"}, 32'(underflow), 0);
        chk({tag, "_rdv"}, 32'(rd_valid), 0);
        chk({tag, "_rdd"}, 32'(rd_data), 0);
    endtask

    // Pop order for the wrap test: last ten of the refill, then the ten push&pop words.
    function automatic logic [3:0] exp5(input int k);
        if (k < 10)
            return 4'(((k + 10) * 3 + 1) & 15);
        return 4'(((k - 10) + 7) & 15);
    endfunction

    initial begin
        push = 1'b0; pop = 1'b0; wr_data = 4'h0; clear_err = 1'b0;
        reset = 1'b1;
        #2 reset = 1'b0;

        // 1: reset held with push requested
        push = 1'b1; wr_data = 4'h5;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals("rst_hold");
        @(negedge clk);
        push = 1'b0;
        reset = 1'b1;

        // 2: push 3,7,A then pop three times
        cyc(1, 0, 4'h3, 0); chk("t2_cnt1", 32'(count), 1);
        chk("t2_empty0", 32'(empty), 0);
        cyc(1, 0, 4'h7, 0); chk("t2_cnt2", 32'(count), 2);
        cyc(1, 0, 4'hA, 0); chk("t2_cnt3", 32'(count), 3);
        cyc(0, 1, 4'h0, 0); chk("t2_cnt_p1", 32'(count), 2);
        chk("t2_rdv_lat", 32'(rd_valid), 0);
        cyc(0, 1, 4'h0, 0); chk("t2_rdv1", 32'(rd_valid), 1);
        chk("t2_rdd1", 32'(rd_data), 4'h3);
        chk("t2_cnt_p2", 32'(count), 1);
        cyc(0, 1, 4'h0, 0); chk("t2_rdv2", 32'(rd_valid), 1);
        chk("t2_rdd2", 32'(rd_data), 4'h7);
        chk("t2_cnt_p3", 32'(count), 0);
        chk("t2_empty1", 32'(empty), 1);
        cyc(0, 0, 4'h0, 0); chk("t2_rdv3", 32'(rd_valid), 1);
        chk("t2_rdd3", 32'(rd_data), 4'hA);
        cyc(0, 0, 4'h0, 0); chk("t2_rdv_end", 32'(rd_valid), 0);
        chk("t2_rdd_hold", 32'(rd_data), 4'hA);

        // 3: fill to 32, overflow, drain in order
        for (int i = 0; i < 32; i++) begin
            cyc(1, 0, 4'(i & 15), 0);
            if (i == 30) chk("t3_full_31", 32'(full), 0);
        end
        chk("t3_full", 32'(full), 1);
        chk("t3_cnt32", 32'(count), 32);
        cyc(1, 0, 4'hE, 0);
        chk("t3_ovf", 32'(overflow), 1);
        chk("t3_cnt_hold", 32'(count), 32);
        cyc(0, 0, 4'h0, 1); chk("t3_ovf_clr", 32'(overflow), 0);
        for (int i = 0; i < 32; i++) begin
            cyc(0, 1, 4'h0, 0);
            if (i > 0) begin
                chk("t3_rdv", 32'(rd_valid), 1);
                chk("t3_rdd", 32'(rd_data), 32'((i - 1) & 15));
            end
        end
        cyc(0, 0, 4'h0, 0);
        chk("t3_rdd_last", 32'(rd_data), 4'hF);
        chk("t3_empty", 32'(empty), 1);
        chk("t3_udf_none", 32'(underflow), 0);

        // 4: pop when empty
        cyc(0, 1, 4'h0, 0); chk("t4_udf", 32'(underflow), 1);
        chk("t4_cnt", 32'(count), 0);
        cyc(0, 0, 4'h0, 0); chk("t4_rdv", 32'(rd_valid), 0);
        chk("t4_rdd", 32'(rd_data), 4'hF);
        chk("t4_udf_sticky", 32'(underflow), 1);
        cyc(0, 0, 4'h0, 1); chk("t4_udf_clr", 32'(underflow), 0);
        cyc(0, 1, 4'h0, 1); chk("t4_set_wins", 32'(underflow), 1);
        cyc(0, 0, 4'h0, 1); chk("t4_udf_clr2", 32'(underflow), 0);

        // 5: pointer wrap and concurrent push&pop
        for (int i = 0; i < 20; i++) cyc(1, 0, 4'(i & 15), 0);
        chk("t5_cnt20", 32'(count), 20);
        for (int i = 0; i < 20; i++) begin
            cyc(0, 1, 4'h0, 0);
            if (i > 0) chk("t5_rdd_a", 32'(rd_data), 32'((i - 1) & 15));
        end
        cyc(0, 0, 4'h0, 0);
        chk("t5_rdd_a_last", 32'(rd_data), 4'h3);
        chk("t5_empty", 32'(empty), 1);
        for (int i = 0; i < 20; i++) cyc(1, 0, 4'((i * 3 + 1) & 15), 0);
        chk("t5_cnt20b", 32'(count), 20);
        for (int i = 0; i < 10; i++) begin
            cyc(1, 1, 4'((i + 7) & 15), 0);
            chk("t5_pp_cnt", 32'(count), 20);
            if (i > 0) begin
                chk("t5_pp_rdv", 32'(rd_valid), 1);
                chk("t5_pp_rdd", 32'(rd_data), 32'(((i - 1) * 3 + 1) & 15));
            end
        end
        cyc(0, 0, 4'h0, 0);
        chk("t5_pp_last", 32'(rd_data), 4'hC);
        for (int i = 0; i < 20; i++) begin
            cyc(0, 1, 4'h0, 0);
            if (i > 0) chk("t5_drain", 32'(rd_data), 32'(exp5(i - 1)));
        end
        cyc(0, 0, 4'h0, 0);
        chk("t5_drain_last", 32'(rd_data), 32'(exp5(19)));
        chk("t5_empty_end", 32'(empty), 1);
        chk("t5_flags", 32'({overflow, underflow}), 0);

        // 6: push&pop on empty, then reset right after an accepted pop
        cyc(1, 1, 4'h9, 0);
        chk("t6_cnt1", 32'(count), 1);
        chk("t6_udf", 32'(underflow), 1);
        chk("t6_rdv", 32'(rd_valid), 0);
        cyc(0, 1, 4'h0, 0);
        chk("t6_cnt0", 32'(count), 0);
        @(negedge clk);
        pop = 1'b0;
        reset = 1'b0;
        #1;
        chk_reset_vals("t6_rst_async");
        @(posedge clk);
        #1;
        chk_reset_vals("t6_rst_edge");
        @(negedge clk);
        reset = 1'b1;
        cyc(0, 0, 4'h0, 0);
        chk_reset_vals("t6_post");
        cyc(0, 0, 4'h0, 0);
        chk("t6_post_rdv2", 32'(rd_valid), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
